// File: rtl/ternary_mvm_engine.sv
// Ternary matrix-vector multiply engine: streams 2-bit weight codes and signed vector
// elements over a 16-bit valid/ready port. Optional build macro: TERNARY_SAT_EN.
module ternary_mvm_engine #(
    parameter int IN_LEN    = 14,
    parameter int OUT_LEN   = 7,
    parameter int BIT_WIDTH = 8,
    parameter int ACC_WIDTH = BIT_WIDTH + $clog2(IN_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_data,
    input  logic                 reload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 weights_ok
);
    localparam int N_W     = OUT_LEN * IN_LEN;
    localparam int W_WORDS = (N_W + 7) / 8;
    localparam int CNT_MAX = (W_WORDS > IN_LEN) ? ((W_WORDS > OUT_LEN) ? W_WORDS : OUT_LEN)
                                                : ((IN_LEN > OUT_LEN) ? IN_LEN : OUT_LEN);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [1:0] {
        S_LOAD_W  = 2'd0,
        S_LOAD_X  = 2'd1,
        S_COMPUTE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_weights_ok;
    logic [2*N_W-1:0]              r_wt;
    logic [BIT_WIDTH-1:0]          r_x   [IN_LEN];
    logic [ACC_WIDTH-1:0]          r_res [OUT_LEN];
    logic                          w_last;
    logic                          w_wr_w;
    logic                          w_wr_x;
    logic [2*IN_LEN-1:0]           w_row;
    logic signed [ACC_WIDTH-1:0]   w_xe;
    logic signed [ACC_WIDTH-1:0]   w_sum;
    logic signed [ACC_WIDTH-1:0]   w_res;
    logic [ACC_WIDTH-1:0]          w_out;

    assign w_wr_w     = (r_state == S_LOAD_W) && in_valid && !reload;
    assign w_wr_x     = (r_state == S_LOAD_X) && in_valid && !reload;
    assign out_valid  = (r_state == S_DRAIN);
    assign weights_ok = r_weights_ok;
    assign out_data   = w_out;

    // Input ready decodes from state; reload masks it only while loading the vector.
    always_comb begin
        case (r_state)
            S_LOAD_W: in_ready = 1'b1;
            S_LOAD_X: in_ready = !reload;
            default:  in_ready = 1'b0;
        endcase
    end

    // Terminal-count decode for whichever phase the shared counter is tracking.
    always_comb begin
        case (r_state)
            S_LOAD_W:  w_last = (r_cnt == CNT_W'(W_WORDS - 1));
            S_LOAD_X:  w_last = (r_cnt == CNT_W'(IN_LEN - 1));
            S_COMPUTE: w_last = (r_cnt == CNT_W'(OUT_LEN - 1));
            S_DRAIN:   w_last = (r_cnt == CNT_W'(OUT_LEN - 1));
            default:   w_last = 1'b0;
        endcase
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD_W:  if (w_wr_w && w_last) w_next = S_LOAD_X; else w_next = r_state;
            S_LOAD_X:  if (reload) w_next = S_LOAD_W;
                       else if (w_wr_x && w_last) w_next = S_COMPUTE;
                       else w_next = r_state;
            S_COMPUTE: if (w_last) w_next = S_DRAIN; else w_next = r_state;
            S_DRAIN:   if (out_ready && w_last) w_next = S_LOAD_X; else w_next = r_state;
            default:   w_next = S_LOAD_W;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LOAD_W;
        else        r_state <= w_next;
    end

    // Shared beat/row/index counter; clears on every phase change and on reload in LOAD_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((w_next != r_state) || ((r_state == S_LOAD_W) && reload)) begin
            r_cnt <= '0;
        end else if (w_wr_w || w_wr_x || (r_state == S_COMPUTE) ||
                     ((r_state == S_DRAIN) && out_ready)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Weight-matrix-complete flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_weights_ok <= 1'b0;
        else if (w_wr_w && w_last)                 r_weights_ok <= 1'b1;
        else if ((r_state == S_LOAD_X) && reload)  r_weights_ok <= 1'b0;
    end

    // Weight store; padding fields of the last beat are never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wt <= '0;
        end else begin
            for (int k = 0; k < N_W; k++) begin
                if (w_wr_w && (r_cnt == CNT_W'(k / 8)))
                    r_wt[2*k +: 2] <= in_data[2*(k % 8) +: 2];
            end
        end
    end

    // Vector store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IN_LEN; i++) r_x[i] <= '0;
        end else begin
            for (int i = 0; i < IN_LEN; i++) begin
                if (w_wr_x && (r_cnt == CNT_W'(i))) r_x[i] <= in_data[BIT_WIDTH-1:0];
            end
        end
    end

    // Row select of the weight store for the row being computed.
    always_comb begin
        w_row = '0;
        for (int r = 0; r < OUT_LEN; r++) begin
            if (r_cnt == CNT_W'(r)) w_row = r_wt[2*IN_LEN*r +: 2*IN_LEN];
            else                    w_row = w_row;
        end
    end

    // Ternary dot product: each code adds, subtracts or skips its element (10 is a zero).
    always_comb begin
        w_sum = '0;
        w_xe  = '0;
        for (int c = 0; c < IN_LEN; c++) begin
            w_xe = {{(ACC_WIDTH-BIT_WIDTH){r_x[c][BIT_WIDTH-1]}}, r_x[c]};
            case (w_row[2*c +: 2])
                2'b01:   w_sum = w_sum + w_xe;
                2'b11:   w_sum = w_sum - w_xe;
                default: w_sum = w_sum;
            endcase
        end
    end

`ifdef TERNARY_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((32'sd1 <<< (BIT_WIDTH-1)) - 32'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ~SAT_HI;

    // Clamp to the input element range.
    always_comb begin
        if (w_sum > SAT_HI)      w_res = SAT_HI;
        else if (w_sum < SAT_LO) w_res = SAT_LO;
        else                     w_res = w_sum;
    end
`else
    // Full-precision result.
    always_comb begin
        w_res = w_sum;
    end
`endif

    // Result registers, one row per COMPUTE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < OUT_LEN; r++) r_res[r] <= '0;
        end else begin
            for (int r = 0; r < OUT_LEN; r++) begin
                if ((r_state == S_COMPUTE) && (r_cnt == CNT_W'(r))) r_res[r] <= w_res;
            end
        end
    end

    // Output mux; zero outside DRAIN.
    always_comb begin
        w_out = '0;
        if (r_state == S_DRAIN) begin
            for (int r = 0; r < OUT_LEN; r++) begin
                if (r_cnt == CNT_W'(r)) w_out = r_res[r];
                else                    w_out = w_out;
            end
        end else begin
            w_out = '0;
        end
    end
endmodule

// File: tb/tb_ternary_mvm_engine.sv
// Directed testbench for ternary_mvm_engine at default parameters (14x7, 8-bit, 12-bit results).
module tb_ternary_mvm_engine;
    localparam int IN_LEN  = 14;
    localparam int OUT_LEN = 7;
    localparam int W_WORDS = 13;
    localparam int ACC_W   = 12;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [15:0]             in_data = 16'h0000;
    logic                    reload = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [ACC_W-1:0] out_data;
    logic                    weights_ok;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0]             xv   [IN_LEN];
    logic [15:0]             mw   [W_WORDS];
    logic signed [ACC_W-1:0] got  [OUT_LEN];
    logic signed [ACC_W-1:0] expv [OUT_LEN];
    int                      tmo;

    ternary_mvm_engine #(.IN_LEN(14), .OUT_LEN(7), .BIT_WIDTH(8), .ACC_WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .reload(reload), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .weights_ok(weights_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_words(input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = d;
        end
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic send_vec();
        for (int i = 0; i < IN_LEN; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = xv[i];
        end
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic send_mixed_weights();
        for (int i = 0; i < W_WORDS; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = mw[i];
        end
        @(negedge clk); in_valid = 1'b0;
    endtask

    // Gathers OUT_LEN results with out_ready held high; counts bounded-wait expiries in tmo.
    task automatic collect_results();
        out_ready = 1'b1;
        for (int i = 0; i < OUT_LEN; i++) begin
            int w = 0;
            while (!out_valid && w < 40) begin @(negedge clk); w++; end
            if (!out_valid) tmo++;
            got[i] = out_data;
            @(negedge clk);
        end
    endtask

    task automatic set_x1();
        xv = '{16'h0005, 16'hFFFD, 16'h0064, 16'h0080, 16'h007F, 16'h0000, 16'h0007,
               16'h0001, 16'h0002, 16'h00FC, 16'h009C, 16'h00FF, 16'h003C, 16'h00F7};
    endtask

    task automatic set_x2();
        xv = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70,
               16'd1,  16'd2,  16'd3,  16'd4,  16'd5,  16'd6,  16'd7};
    endtask

    // Row r: +1 at column r, -1 at column r+7, zeros elsewhere (reserved 10 on odd columns).
    task automatic build_mixed();
        logic [16*W_WORDS-1:0] flat;
        flat = {(16*W_WORDS){1'b1}};
        for (int r = 0; r < OUT_LEN; r++) begin
            for (int c = 0; c < IN_LEN; c++) begin
                int k = r * IN_LEN + c;
                if (c == r)          flat[2*k +: 2] = 2'b01;
                else if (c == r + 7) flat[2*k +: 2] = 2'b11;
                else if (c % 2 == 1) flat[2*k +: 2] = 2'b10;
                else                 flat[2*k +: 2] = 2'b00;
            end
        end
        for (int i = 0; i < W_WORDS; i++) mw[i] = flat[16*i +: 16];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (weights_ok !== 1'b0) begin n_bad++; $display("FAIL reset_weights_ok got %b want 0", weights_ok); end
        n_cmp++; if (out_data !== 12'sd0) begin n_bad++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_all_ones();
        int n;
        send_words(16'h5555, W_WORDS);
        n_cmp++; if (weights_ok !== 1'b1) begin n_bad++; $display("FAIL ones_weights_ok got %b want 1", weights_ok); end
        for (int i = 0; i < IN_LEN; i++) xv[i] = 16'h0001;
        send_vec();
        n = 1;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL ones_latency got %0d edges want 8", n); end
        tmo = 0;
        collect_results();
        n_cmp++; if (tmo !== 0) begin n_bad++; $display("FAIL ones_timeout got %0d want 0", tmo); end
        for (int i = 0; i < OUT_LEN; i++) begin
            n_cmp++; if (got[i] !== 12'sd14) begin n_bad++; $display("FAIL ones_result[%0d] got %0d want 14", i, got[i]); end
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ones_drain_end got %b want 0", out_valid); end
    endtask

    task automatic test_reload_collision();
        reload = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL coll_in_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (weights_ok !== 1'b0) begin n_bad++; $display("FAIL coll_weights_ok got %b want 0", weights_ok); end
        n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL coll_state_load_w in_ready got %b want 1", in_ready); end
        @(negedge clk); reload = 1'b0; in_valid = 1'b0;
        send_words(16'hFFFF, W_WORDS - 1);
        n_cmp++; if (weights_ok !== 1'b0) begin n_bad++; $display("FAIL neg_early_weights_ok got %b want 0", weights_ok); end
        send_words(16'hFFFF, 1);
        n_cmp++; if (weights_ok !== 1'b1) begin n_bad++; $display("FAIL neg_weights_ok got %b want 1", weights_ok); end
        for (int i = 0; i < IN_LEN; i++) xv[i] = 16'hAB80;
        send_vec();
        tmo = 0;
        collect_results();
        n_cmp++; if (tmo !== 0) begin n_bad++; $display("FAIL neg_timeout got %0d want 0", tmo); end
        for (int i = 0; i < OUT_LEN; i++) begin
`ifdef TERNARY_SAT_EN
            n_cmp++; if (got[i] !== 12'sd127) begin n_bad++; $display("FAIL neg_result[%0d] got %0d want 127", i, got[i]); end
`else
            n_cmp++; if (got[i] !== 12'sh700) begin n_bad++; $display("FAIL neg_result[%0d] got %0d want 1792", i, got[i]); end
`endif
        end
    endtask

    task automatic test_backpressure();
        int w;
        @(negedge clk); reload = 1'b1;
        @(negedge clk); reload = 1'b0;
        build_mixed();
        send_mixed_weights();
        set_x1();
        send_vec();
        expv[0] = 12'sd4;   expv[1] = -12'sd5;  expv[2] = 12'sd104; expv[3] = -12'sd28;
`ifdef TERNARY_SAT_EN
        expv[4] = 12'sd127;
`else
        expv[4] = 12'sd128;
`endif
        expv[5] = -12'sd60; expv[6] = 12'sd16;
        out_ready = 1'b1;
        w = 0;
        while (!out_valid && w < 40) begin @(negedge clk); w++; end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_wait got %b want 1", out_valid); end
        for (int i = 0; i < OUT_LEN; i++) begin
            if (i == 3) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    n_cmp++; if (out_data !== expv[3] || out_valid !== 1'b1)
                        begin n_bad++; $display("FAIL bp_hold[%0d] got %0d/%b want %0d/1", s, out_data, out_valid, expv[3]); end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            n_cmp++; if (out_data !== expv[i]) begin n_bad++; $display("FAIL bp_result[%0d] got %0d want %0d", i, out_data, expv[i]); end
            @(negedge clk);
        end
        n_cmp++; if (out_valid !== 1'b0 || weights_ok !== 1'b1)
            begin n_bad++; $display("FAIL bp_end got valid=%b ok=%b want 0/1", out_valid, weights_ok); end
    endtask

    task automatic test_reuse();
        set_x2();
        send_vec();
        tmo = 0;
        collect_results();
        n_cmp++; if (tmo !== 0) begin n_bad++; $display("FAIL reuse_timeout got %0d want 0", tmo); end
        for (int i = 0; i < OUT_LEN; i++) begin
            n_cmp++; if (got[i] !== 12'(9 * (i + 1))) begin n_bad++; $display("FAIL reuse_result[%0d] got %0d want %0d", i, got[i], 9 * (i + 1)); end
        end
    endtask

    task automatic test_async_reset();
        set_x1();
        send_vec();
        @(posedge clk); @(posedge clk); #2;
        n_cmp++; if (in_ready !== 1'b0 || weights_ok !== 1'b1)
            begin n_bad++; $display("FAIL ar_precheck got ready=%b ok=%b want 0/1", in_ready, weights_ok); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL ar_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL ar_out_valid got %b want 0", out_valid); end
        n_cmp++; if (weights_ok !== 1'b0) begin n_bad++; $display("FAIL ar_weights_ok got %b want 0", weights_ok); end
        n_cmp++; if (out_data !== 12'sd0) begin n_bad++; $display("FAIL ar_out_data got %0d want 0", out_data); end
        @(negedge clk); rst_n = 1'b1;
        send_mixed_weights();
        set_x2();
        send_vec();
        tmo = 0;
        collect_results();
        n_cmp++; if (tmo !== 0) begin n_bad++; $display("FAIL ar_timeout got %0d want 0", tmo); end
        for (int i = 0; i < OUT_LEN; i++) begin
            n_cmp++; if (got[i] !== 12'(9 * (i + 1))) begin n_bad++; $display("FAIL ar_result[%0d] got %0d want %0d", i, got[i], 9 * (i + 1)); end
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_reload_collision();
        test_backpressure();
        test_reuse();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
